l1_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one L2-side message port between `NUM_PORTS` L1 caching-logic instances, for example an I-cache and a D-cache on one core. It sits between each L1's `cache2mem_*`/`mem2cache_*` bus and the single downstream bus interface. It serialises whole transactions: one request out, one response back, then release. Message encodings (`NO_REQ`, `R_REQ`, `WB_REQ`, `FLUSH`, `MEM_NO_MSG`, `MEM_RESP`, …) come from the shared message-definitions include.

---
 rtl/l1_mem_arbiter_pkg.sv | 32 +++
 rtl/l1_mem_arbiter_picker.sv | 30 +++
 rtl/l1_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_l1_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_arbiter_pkg.sv
// Shared cache message codes, arbiter state encoding and log2 helper.
// Imported by the L1-side arbiter and its priority picker.
package l1_mem_arbiter_pkg;

  localparam logic [3:0] NO_REQ    = 4'd0;
  localparam logic [3:0] R_REQ     = 4'd1;
  localparam logic [3:0] WB_REQ    = 4'd2;
  localparam logic [3:0] FLUSH     = 4'd3;
  localparam logic [3:0] FLUSH_S   = 4'd4;
  localparam logic [3:0] WS_BCAST  = 4'd5;
  localparam logic [3:0] RFO_BCAST = 4'd6;

  localparam logic [3:0] MEM_NO_MSG = 4'd0;
  localparam logic [3:0] MEM_READY  = 4'd1;
  localparam logic [3:0] MEM_RESP   = 4'd2;
  localparam logic [3:0] MEM_RESP_M = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Ceiling log2, never below 1 so a 1-bit index always exists.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after
// the pointer, searching upward with wrap-around.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  int w_idx;

  // Walk offsets high to low so the smallest offset wins last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_req[w_idx]) begin
        o_idx   = IW'(w_idx);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one L2-side message port between
// several L1 caches; one whole transaction at a time.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 128
) (
  input  logic clock,
  input  logic reset,

  input  logic [NUM_PORTS*MSG_BITS-1:0]     cache2arb_msg,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] cache2arb_address,
  input  logic [NUM_PORTS*CACHE_WIDTH-1:0]  cache2arb_data,

  output logic [NUM_PORTS*MSG_BITS-1:0]     arb2cache_msg,
  output logic [NUM_PORTS*ADDRESS_BITS-1:0] arb2cache_address,
  output logic [NUM_PORTS*CACHE_WIDTH-1:0]  arb2cache_data,

  output logic [MSG_BITS-1:0]     arb2mem_msg,
  output logic [ADDRESS_BITS-1:0] arb2mem_address,
  output logic [CACHE_WIDTH-1:0]  arb2mem_data,

  input  logic [MSG_BITS-1:0]     mem2arb_msg,
  input  logic [ADDRESS_BITS-1:0] mem2arb_address,
  input  logic [CACHE_WIDTH-1:0]  mem2arb_data,

  output logic [log2(NUM_PORTS)-1:0] grant,
  output logic                       busy
);

  localparam int GW = log2(NUM_PORTS);
  localparam logic [MSG_BITS-1:0] L_NO_REQ = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] L_NO_MSG = MSG_BITS'(MEM_NO_MSG);

  arb_state_t r_state;
  arb_state_t w_next;

  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] w_win;
  logic [GW-1:0] w_ptr_inc;
  logic          w_found;
  logic          w_release;

  logic [NUM_PORTS-1:0]    w_req;
  logic [MSG_BITS-1:0]     w_g_msg;
  logic [ADDRESS_BITS-1:0] w_g_addr;
  logic [CACHE_WIDTH-1:0]  w_g_data;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      w_req[i] =
        cache2arb_msg[i*MSG_BITS +: MSG_BITS] != L_NO_REQ;
  end

  rr_priority_picker #(
    .N  (NUM_PORTS),
    .IW (GW)
  ) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_g_msg =
    cache2arb_msg[int'(r_grant)*MSG_BITS +: MSG_BITS];
  assign w_g_addr =
    cache2arb_address[int'(r_grant)*ADDRESS_BITS +: ADDRESS_BITS];
  assign w_g_data =
    cache2arb_data[int'(r_grant)*CACHE_WIDTH +: CACHE_WIDTH];

  assign w_ptr_inc = (int'(r_grant) == NUM_PORTS - 1) ?
                     '0 : r_grant + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) r_grant <= w_win;
      if (w_release) r_rr_ptr <= w_ptr_inc;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_release         = 1'b0;
    arb2mem_msg       = L_NO_REQ;
    arb2mem_address   = '0;
    arb2mem_data      = '0;
    arb2cache_msg     = {NUM_PORTS{L_NO_MSG}};
    arb2cache_address = '0;
    arb2cache_data    = '0;

    unique case (r_state)
      IDLE:  if (w_found) w_next = GRANT;
      GRANT: if (mem2arb_msg != L_NO_MSG) w_next = RESP;
      RESP: begin
        if (w_g_msg == L_NO_REQ && mem2arb_msg == L_NO_MSG) begin
          w_next    = IDLE;
          w_release = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase

    // Request forwarded and response routed for the whole ownership.
    if (r_state != IDLE) begin
      arb2mem_msg     = w_g_msg;
      arb2mem_address = w_g_addr;
      arb2mem_data    = w_g_data;
      arb2cache_msg[int'(r_grant)*MSG_BITS +: MSG_BITS] =
        mem2arb_msg;
      arb2cache_address[int'(r_grant)*ADDRESS_BITS +: ADDRESS_BITS] =
        mem2arb_address;
      arb2cache_data[int'(r_grant)*CACHE_WIDTH +: CACHE_WIDTH] =
        mem2arb_data;
    end
  end

  assign busy  = (r_state != IDLE);
  assign grant = r_grant;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter with a behavioural L2 and
// two request-driving L1 port models.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  localparam int NP = 2;
  localparam int MB = 4;
  localparam int AB = 32;
  localparam int CW = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [MB-1:0] c_msg  [NP];
  logic [AB-1:0] c_addr [NP];
  logic [CW-1:0] c_data [NP];

  logic [NP*MB-1:0] cache2arb_msg;
  logic [NP*AB-1:0] cache2arb_address;
  logic [NP*CW-1:0] cache2arb_data;
  logic [NP*MB-1:0] arb2cache_msg;
  logic [NP*AB-1:0] arb2cache_address;
  logic [NP*CW-1:0] arb2cache_data;
  logic [MB-1:0]    arb2mem_msg;
  logic [AB-1:0]    arb2mem_address;
  logic [CW-1:0]    arb2mem_data;
  logic [MB-1:0]    mem2arb_msg;
  logic [AB-1:0]    mem2arb_address;
  logic [CW-1:0]    mem2arb_data;
  logic [0:0]       grant;
  logic             busy;

  assign cache2arb_msg     = {c_msg[1], c_msg[0]};
  assign cache2arb_address = {c_addr[1], c_addr[0]};
  assign cache2arb_data    = {c_data[1], c_data[0]};

  l1_mem_arbiter #(
    .NUM_PORTS    (NP),
    .MSG_BITS     (MB),
    .ADDRESS_BITS (AB),
    .CACHE_WIDTH  (CW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .cache2arb_msg     (cache2arb_msg),
    .cache2arb_address (cache2arb_address),
    .cache2arb_data    (cache2arb_data),
    .arb2cache_msg     (arb2cache_msg),
    .arb2cache_address (arb2cache_address),
    .arb2cache_data    (arb2cache_data),
    .arb2mem_msg       (arb2mem_msg),
    .arb2mem_address   (arb2mem_address),
    .arb2mem_data      (arb2mem_data),
    .mem2arb_msg       (mem2arb_msg),
    .mem2arb_address   (mem2arb_address),
    .mem2arb_data      (mem2arb_data),
    .grant             (grant),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  localparam logic [CW-1:0] D_EE00 =
    128'h99991111_88882222_77773333_66664444;

  task automatic chk(input string tag,
                     input logic [CW-1:0] obs,
                     input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural L2: fixed latency, holds the response until the
  // request on arb2mem drops.
  logic [1:0]    l2_st;
  int            l2_cnt;
  logic [AB-1:0] wr_a [16];
  logic [CW-1:0] wr_d [16];
  int            wr_n = 0;

  function automatic logic [CW-1:0] l2_read(input logic [AB-1:0] a);
    logic [CW-1:0] r;
    r = (a == 32'hEEEEEE00) ? D_EE00 : {4{a ^ 32'h5A5A5A5A}};
    for (int i = 0; i < wr_n && i < 16; i++)
      if (wr_a[i] == a) r = wr_d[i];
    return r;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      l2_st           <= 2'd0;
      l2_cnt          <= 0;
      mem2arb_msg     <= MEM_NO_MSG;
      mem2arb_address <= '0;
      mem2arb_data    <= '0;
    end else begin
      case (l2_st)
        2'd0: begin
          if (arb2mem_msg == R_REQ || arb2mem_msg == WB_REQ) begin
            l2_cnt <= 3;
            l2_st  <= 2'd1;
          end
        end
        2'd1: begin
          if (l2_cnt == 0) begin
            mem2arb_msg     <= MEM_RESP;
            mem2arb_address <= arb2mem_address;
            if (arb2mem_msg == WB_REQ) begin
              mem2arb_data     <= arb2mem_data;
              wr_a[wr_n % 16]  <= arb2mem_address;
              wr_d[wr_n % 16]  <= arb2mem_data;
              wr_n             <= wr_n + 1;
            end else begin
              mem2arb_data <= l2_read(arb2mem_address);
            end
            l2_st <= 2'd2;
          end else begin
            l2_cnt <= l2_cnt - 1;
          end
        end
        default: begin
          if (arb2mem_msg == NO_REQ) begin
            mem2arb_msg     <= MEM_NO_MSG;
            mem2arb_address <= '0;
            mem2arb_data    <= '0;
            l2_st           <= 2'd0;
          end
        end
      endcase
    end
  end

  // Grant log, idle gap before each grant, and protocol monitors.
  int   glog [$];
  int   gaps [$];
  int   idle_cnt  = 0;
  logic prev_busy = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      prev_busy <= busy;
      if (!busy) idle_cnt <= idle_cnt + 1;
      if (busy && !prev_busy) begin
        glog.push_back(int'(grant));
        gaps.push_back(idle_cnt);
        idle_cnt <= 0;
      end
      chk("proto_drop",
          CW'(dut.r_state == GRANT &&
              cache2arb_msg[int'(grant)*MB +: MB] == NO_REQ), '0);
      chk("resp_in_idle",
          CW'(!busy && mem2arb_msg != MEM_NO_MSG), '0);
      for (int q = 0; q < NP; q++) begin
        if (!busy || int'(grant) != q) begin
          chk($sformatf("quiet_msg%0d", q),
              CW'(arb2cache_msg[q*MB +: MB]), CW'(MEM_NO_MSG));
          chk($sformatf("quiet_dat%0d", q),
              arb2cache_data[q*CW +: CW], '0);
        end
      end
    end
  end

  // One L1 transaction: request, wait for the response, hold for
  // `hold` extra cycles, drop, then stay quiet until release.
  task automatic do_req(input int p,
                        input logic [MB-1:0] m,
                        input logic [AB-1:0] a,
                        input logic [CW-1:0] d,
                        input int hold,
                        output logic [CW-1:0] rd);
    int n;
    c_msg[p]  = m;
    c_addr[p] = a;
    c_data[p] = d;
    n = 0;
    while (arb2cache_msg[p*MB +: MB] !== MEM_RESP && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk($sformatf("resp_timeout_p%0d", p), CW'(n < 400), CW'(1));
    rd = arb2cache_data[p*CW +: CW];
    for (int h = 0; h <= hold; h++) begin
      @(posedge clock); #1;
      chk($sformatf("hold_state_p%0d", p),
          CW'(dut.r_state), CW'(RESP));
      chk($sformatf("hold_grant_p%0d", p), CW'(grant), CW'(p));
    end
    c_msg[p]  = NO_REQ;
    c_addr[p] = '0;
    c_data[p] = '0;
    n = 0;
    while (arb2cache_msg[p*MB +: MB] !== MEM_NO_MSG && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk($sformatf("drop_timeout_p%0d", p), CW'(n < 400), CW'(1));
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [CW-1:0] rd0, rd1;
  int b, n, t0;

  initial begin
    for (int i = 0; i < NP; i++) begin
      c_msg[i]  = NO_REQ;
      c_addr[i] = '0;
      c_data[i] = '0;
    end
    do_reset();

    // Reset state
    chk("rst_state", CW'(dut.r_state), CW'(IDLE));
    chk("rst_grant", CW'(grant), '0);
    chk("rst_busy", CW'(busy), '0);
    chk("rst_rr", CW'(dut.r_rr_ptr), '0);
    chk("rst_mem_msg", CW'(arb2mem_msg), CW'(NO_REQ));
    chk("rst_mem_addr", CW'(arb2mem_address), '0);
    chk("rst_mem_data", arb2mem_data, '0);
    chk("rst_c_msg", CW'(arb2cache_msg), CW'({MEM_NO_MSG, MEM_NO_MSG}));
    chk("rst_c_addr", CW'(arb2cache_address), '0);
    mon_en = 1'b1;

    // Single request from port0
    @(posedge clock); #1;
    c_msg[0]  = R_REQ;
    c_addr[0] = 32'hEEEEEE00;
    @(posedge clock); #1;
    chk("t1_busy", CW'(busy), CW'(1));
    chk("t1_grant", CW'(grant), '0);
    chk("t1_mem_msg", CW'(arb2mem_msg), CW'(R_REQ));
    chk("t1_mem_addr", CW'(arb2mem_address), CW'(32'hEEEEEE00));
    n = 0;
    while (mem2arb_msg === MEM_NO_MSG && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t1_latency", CW'(n), CW'(5));
    chk("t1_state_same", CW'(dut.r_state), CW'(GRANT));
    chk("t1_p0_msg", CW'(arb2cache_msg[0 +: MB]), CW'(MEM_RESP));
    chk("t1_p0_data", arb2cache_data[0 +: CW], D_EE00);
    chk("t1_p1_msg", CW'(arb2cache_msg[MB +: MB]), CW'(MEM_NO_MSG));
    @(posedge clock); #1;
    chk("t1_resp", CW'(dut.r_state), CW'(RESP));
    c_msg[0]  = NO_REQ;
    c_addr[0] = '0;
    n = 0;
    while (arb2cache_msg[0 +: MB] !== MEM_NO_MSG && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    chk("t1_idle", CW'(busy), '0);
    chk("t1_rr", CW'(dut.r_rr_ptr), CW'(1));
    chk("t1_idle_msg", CW'(arb2mem_msg), CW'(NO_REQ));

    // Simultaneous requests out of reset
    do_reset();
    b = glog.size();
    fork
      do_req(0, R_REQ, 32'h100, '0, 0, rd0);
      do_req(1, WB_REQ, 32'h200, 128'hCAFE0000_0000BEEF, 0, rd1);
    join
    chk("t2_first", CW'(glog[b]), '0);
    chk("t2_second", CW'(glog[b+1]), CW'(1));
    chk("t2_bubble", CW'(gaps[b+1]), CW'(1));
    chk("t2_rr", CW'(dut.r_rr_ptr), '0);
    chk("t2_rd0", rd0, {4{32'h5A5A5B5A}});
    chk("t2_rd1", rd1, 128'hCAFE0000_0000BEEF);

    // Fairness under continuous requests
    do_reset();
    b = glog.size();
    fork
      for (int k = 0; k < 3; k++)
        do_req(0, R_REQ, 32'h700, '0, 0, rd0);
      for (int k = 0; k < 3; k++)
        do_req(1, R_REQ, 32'h800, '0, 0, rd1);
    join
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), CW'(glog[b+k]), CW'(k % 2));
    for (int k = 1; k < 6; k++)
      chk($sformatf("t3_gap%0d", k), CW'(gaps[b+k]), CW'(1));

    // Slow release by port1 with port0 waiting
    b = glog.size();
    fork
      do_req(1, R_REQ, 32'h300, '0, 3, rd1);
      begin
        @(posedge clock); #1;
        do_req(0, R_REQ, 32'h900, '0, 0, rd0);
      end
    join
    chk("t4_first", CW'(glog[b]), CW'(1));
    chk("t4_second", CW'(glog[b+1]), '0);
    chk("t4_count", CW'(glog.size() - b), CW'(2));
    chk("t4_rd1", rd1, {4{32'h5A5A595A}});
    chk("t4_rd0", rd0, {4{32'h5A5A535A}});

    // Reset while port1 holds the grant
    c_msg[1]  = R_REQ;
    c_addr[1] = 32'h600;
    @(posedge clock); #1;
    chk("t5_grant", CW'(grant), CW'(1));
    chk("t5_state", CW'(dut.r_state), CW'(GRANT));
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t5_rst_state", CW'(dut.r_state), CW'(IDLE));
    chk("t5_rst_grant", CW'(grant), '0);
    chk("t5_rst_busy", CW'(busy), '0);
    chk("t5_rst_rr", CW'(dut.r_rr_ptr), '0);
    chk("t5_rst_mmsg", CW'(arb2mem_msg), CW'(NO_REQ));
    chk("t5_rst_maddr", CW'(arb2mem_address), '0);
    chk("t5_rst_mdata", arb2mem_data, '0);
    chk("t5_rst_cmsg", CW'(arb2cache_msg),
        CW'({MEM_NO_MSG, MEM_NO_MSG}));
    chk("t5_rst_caddr", CW'(arb2cache_address), '0);
    c_msg[1]  = NO_REQ;
    c_addr[1] = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    b = glog.size();
    do_req(1, R_REQ, 32'h600, '0, 0, rd1);
    chk("t5_regrant", CW'(glog[b]), CW'(1));
    chk("t5_rd1", rd1, {4{32'h5A5A5C5A}});

    // Two L1 streams against the behavioural L2
    do_reset();
    t0 = cyc;
    fork
      begin
        logic [CW-1:0] r;
        do_req(0, R_REQ, 32'hEEEEEE04, '0, 0, r);
        chk("t6_rd_ee04", r, {4{32'hB4B4B45E}});
        do_req(0, WB_REQ, 32'hEEEEEE00, 128'h01020304, 0, r);
        do_req(0, R_REQ, 32'hEEEEEE00, '0, 0, r);
        chk("t6_readback", r, 128'h01020304);
      end
      begin
        logic [CW-1:0] r;
        do_req(1, R_REQ, 32'h300, '0, 0, r);
        chk("t6_p1_300", r, {4{32'h5A5A595A}});
        do_req(1, R_REQ, 32'h400, '0, 0, r);
        chk("t6_p1_400", r, {4{32'h5A5A5E5A}});
        do_req(1, R_REQ, 32'h500, '0, 0, r);
        chk("t6_p1_500", r, {4{32'h5A5A5F5A}});
      end
    join
    chk("t6_in_time", CW'((cyc - t0) < 400), CW'(1));

    repeat (2) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
